muller_pipe: RTL
================

// Module: muller_pipe
// PURPOSE
//  Clocked model of a 2-phase bundled-data micropipeline FIFO: a chain of DEPTH
//  Muller C-elements controlling DEPTH data latches of WIDTH bits.
//  Parametrised successor of the standalone muller gate.
//  Sits between two 2-phase handshake domains of the async datapath.
//  Allows synchronous simulation and FPGA prototyping of the pipeline.
// PARAMETERS
//  WIDTH  8  data bits per token (>=1)
//  DEPTH  4  number of C-element stages = token capacity (>=2)
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  rst       in   1      reset, asynchronous, active-low
//  in_req    in   1      producer request (2-phase: each toggle = new token)
//  in_ack    out  1      producer acknowledge (= stage 0 C-element state)
//  in_data   in   WIDTH  producer data, bundled with in_req
//  out_req   out  1      consumer request (= stage DEPTH-1 C-element state)
//  out_ack   in   1      consumer acknowledge (toggle = token consumed)
//  out_data  out  WIDTH  data held in stage DEPTH-1
//  occupancy out  $clog2(DEPTH+1)  tokens held (only with MULLER_PIPE_OCC_EN)
//  full      out  1      occupancy==DEPTH (only with MULLER_PIPE_OCC_EN)
//  empty     out  1      occupancy==0 (only with MULLER_PIPE_OCC_EN)
// BEHAVIOUR
//  - State c[0..DEPTH-1]. Boundaries: c[-1]=in_req, c[DEPTH]=out_ack.
//  - C(a,b) = a when a==b, else hold.
//  - Each edge, all stages update simultaneously from pre-edge values:
//    c[i] <= C(c[i-1], ~c[i+1]).
//  - Data: d[i] <= d[i-1] on the edge where c[i] changes; d[-1]=in_data.
//    Otherwise d[i] holds.
//  - in_ack=c[0], out_req=c[DEPTH-1], out_data=d[DEPTH-1]; all registered.
//  - No combinational input->output paths.
//  - Reset (rst=0, async): all c=0, d=0, in_ack=0, out_req=0, out_data=0.
//    Optional outputs reset to occupancy=0, empty=1, full=0.
//  - Reset mid-operation discards all tokens.
//  - Environment drives in_req=0 and out_ack=0 at reset release.
//    A 1 on either at release is a pending transition and is processed.
//  - Producer protocol:
//    - in_req!=in_ack means a request is pending.
//    - in_data stable from the in_req toggle until in_ack matches.
//    - Toggling in_req while pending is illegal (undefined).
//  - Consumer protocol:
//    - out_req!=out_ack means out_data valid and stable.
//    - Consumer toggles out_ack once per token.
//  - Latency, empty pipe:
//    - in_ack follows an in_req toggle after 1 edge.
//    - out_req toggles DEPTH edges after the in_req toggle is sampled.
//  - Throughput: max one token per 2 cycles at each end.
//  - Token at stage i: c[i] != c[i+1]. Tokens never overtake; order preserved.
//  - Full (DEPTH tokens, consumer stalled): c alternates.
//    - in_req toggle stays unacked until out_ack toggles.
//    - Space ripples back 1 stage/cycle.
//  - Simultaneous in_req and out_ack toggles when full:
//    - out_ack accepted at the first edge.
//    - in_ack follows DEPTH edges later (bubble ripple).
//  - Empty: out_req==out_ack. out_data holds the last token value.
// CONFIGURATION
//  MULLER_PIPE_OCC_EN defined:
//    - occupancy = popcount over i=0..DEPTH-1 of (c[i]^c[i+1]), from registered state.
//    - full/empty decoded from occupancy.
//  MULLER_PIPE_OCC_EN undefined:
//    - occupancy/full/empty ports and logic absent.
//    - Handshake behaviour identical.
// TESTING
//  1 Reset:
//    - rst=0 at arbitrary state -> in_ack=0, out_req=0, out_data=0 immediately.
//    - occupancy=0, empty=1.
//  2 Single token, DEPTH=4, WIDTH=8:
//    - in_data=8'hA5, toggle in_req, out_ack held 0.
//    - in_ack=1 after 1 edge; out_req=1 after 4 edges; out_data=8'hA5.
//    - occupancy=1.
//  3 Fill with consumer stalled:
//    - Push 8'h01..8'h04 -> full=1, occupancy=4.
//    - 5th in_req toggle unacked for >=20 cycles.
//  4 Drain:
//    - From full, toggle out_ack per out_req change.
//    - Read 8'h01,02,03,04 in order; empty=1 at end.
//    - The pending 5th token is accepted after the first out_ack.
//  5 Streaming:
//    - Producer and consumer respond immediately, 100 random tokens.
//    - Data matches a scoreboard.
//    - One token per 2 cycles in steady state.
//  6 Mid-stream reset:
//    - Assert rst with occupancy=3, release with in_req=out_ack=0.
//    - occupancy=0; next pushed token 8'h5A emerges with latency 4.

Source files
------------

// File: rtl/muller_pipe.sv
// Clocked 2-phase bundled-data micropipeline: DEPTH Muller C-elements steering DEPTH data latches.
// Optional occupancy/full/empty outputs are built when MULLER_PIPE_OCC_EN is defined.
module muller_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_data
`ifdef MULLER_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty
`endif
);

  logic [DEPTH-1:0] c_q;
  logic [DEPTH-1:0] c_d;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] d_src [DEPTH];

  // chain[i+1] is stage i; the two ends are the handshake inputs.
  logic [DEPTH+1:0] chain;
  assign chain = {out_ack, c_q, in_req};

  // Stage i takes its predecessor's value once the successor differs from it,
  // i.e. C(c[i-1], ~c[i+1]).
  always_comb begin
    // NOTE: default first so every path assigns c_d and no latch is inferred.
    c_d = c_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (chain[i] != chain[i+2]) c_d[i] = chain[i];
    end
  end

  always_comb begin
    d_src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) d_src[i] = d_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
      // NOTE: the data latches are reset too, so out_data reads 0 after reset.
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      c_q <= c_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (c_d[i] != c_q[i]) d_q[i] <= d_src[i];
      end
    end
  end

  assign in_ack   = c_q[0];
  assign out_req  = c_q[DEPTH-1];
  assign out_data = d_q[DEPTH-1];

`ifdef MULLER_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  // out_ack is sampled so the count depends on registered state only.
  logic ack_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_q <= 1'b0;
    else      ack_q <= out_ack;
  end

  logic [DEPTH:0] tok_chain;
  assign tok_chain = {ack_q, c_q};

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(tok_chain[i] ^ tok_chain[i+1]);
    end
  end

  assign full  = (occupancy == OCC_W'(DEPTH));
  assign empty = (occupancy == '0);
`endif

endmodule
